// File: rtl/fetch_queue.sv
// Multi-word instruction fetch queue: streams aligned 8 B fetches into a DEPTH-entry FIFO
// and presents a 64-bit window at the halfword PC. FETCH_QUEUE_PERF_EN adds perf counters.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_addr_valid,
  input  logic              imem_addr_ready,
  input  logic [63:0]       imem_data,
  input  logic              imem_data_valid,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [63:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid16,
  output logic              inst_valid32,
  output logic              inst_valid64,
  input  logic              advance16,
  input  logic              advance32,
  input  logic              advance64
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 16;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0]      fetch_addr_q, fetch_addr_d, inst_pc_q, inst_pc_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CW-1:0]          count_q, count_d, infl_q, infl_d;
  logic [DW-1:0]          disc_q, disc_d;
  logic [DEPTH-1:0][63:0] mem_q;
  logic [63:0]            w0, w1;
  logic [127:0]           pair;
  logic [1:0]             off;
  logic [3:0]             step, ofs_sum;
  logic                   credit, acc, drop, live, push, pop, v16, v32, v64;

  // Buffered plus outstanding words never exceed DEPTH, so a live response always has a slot.
  assign credit          = ({1'b0, count_q} + {1'b0, infl_q}) < DEPTH_C;
  assign imem_addr_valid = rst_n & credit & ~redirect;
  assign imem_addr       = fetch_addr_q;
  assign acc             = imem_addr_valid & imem_addr_ready;
  assign drop            = imem_data_valid & (disc_q != '0);
  assign live            = imem_data_valid & (disc_q == '0);
  assign push            = live & ~redirect;

  assign off      = inst_pc_q[2:1];
  assign head_nxt = head_q + PW'(1);
  assign w0       = (count_q != '0)      ? mem_q[head_q]   : '0;
  assign w1       = (count_q >= CW'(2))  ? mem_q[head_nxt] : '0;
  assign pair     = {w1, w0} >> {off, 4'b0000};

  assign v16 = (count_q != '0);
  assign v32 = v16 & ((count_q >= CW'(2)) | (off != 2'd3));
  assign v64 = (count_q >= CW'(2)) | (v16 & (off == 2'd0));

  assign inst_data    = pair[63:0];
  assign inst_pc      = inst_pc_q;
  assign inst_valid16 = v16;
  assign inst_valid32 = v32;
  assign inst_valid64 = v64;

  // Highest-priority advance wins; it is dropped outright if its window is not available.
  always_comb begin
    step = '0;
    if (advance16) begin
      if (v16) step = 4'd2;
    end else if (advance32) begin
      if (v32) step = 4'd4;
    end else if (advance64) begin
      if (v64) step = 4'd8;
    end
    ofs_sum = {1'b0, off, 1'b0} + step;
    pop     = ofs_sum[3] & ~redirect;
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    inst_pc_d    = inst_pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    infl_d       = infl_q;
    disc_d       = disc_q;
    if (redirect) begin
      // Everything still on the bus belongs to the old stream and must be dropped.
      fetch_addr_d = redirect_pc & ~ADDR_W'(7);
      inst_pc_d    = redirect_pc & ~ADDR_W'(1);
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      infl_d       = '0;
      disc_d       = disc_q + DW'(infl_q) + DW'(acc) - DW'(imem_data_valid);
    end else begin
      if (acc) fetch_addr_d = fetch_addr_q + ADDR_W'(8);
      inst_pc_d = inst_pc_q + ADDR_W'(step);
      head_d    = head_q + PW'(pop);
      tail_d    = tail_q + PW'(push);
      count_d   = count_q + CW'(push) - CW'(pop);
      infl_d    = infl_q + CW'(acc) - CW'(live);
      disc_d    = disc_q - DW'(drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= RESET_PC & ~ADDR_W'(7);
      inst_pc_q    <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      infl_q       <= '0;
      disc_q       <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      inst_pc_q    <= inst_pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      infl_q       <= infl_d;
      disc_q       <= disc_d;
    end
  end

  // Storage needs no reset: empty lanes are masked by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= imem_data;
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_q, redir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (!v16 && (stall_q != '1))     stall_q <= stall_q + 32'd1;
      if (redirect && (redir_q != '1)) redir_q <= redir_q + 32'd1;
    end
  end

  assign perf_stall_cnt    = stall_q;
  assign perf_redirect_cnt = redir_q;
`endif

endmodule
